multicycle_controller: RTL

//  Multicycle FSM sequencing the 16-bit datapath: fetch, decode, execute, memory, writeback.

---
 rtl/multicycle_controller_if.sv | 29 ++
 rtl/multicycle_controller.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: controller <-> datapath bundle (instruction, flags, selects, enables, strobes).
interface multicycle_controller_if #(parameter int WIDTH = 16, parameter int PSRL = 5);
  logic [WIDTH-1:0] INSTR;
  logic [PSRL-1:0] PSR_OUT;
  logic PC_S;
  logic MEM_S;
  logic [1:0] WD_S;
  logic [1:0] ALUA_S;
  logic [1:0] ALUB_S;
  logic INSTR_EN;
  logic ALU_OUT_EN;
  logic MEM_REG_EN;
  logic PC_EN;
  logic PSR_EN;
  logic SE_SIGN;
  logic REG_WR;
  logic MEM_WE;
  logic HALTED;
  modport master (
    input INSTR, PSR_OUT,
    output PC_S, MEM_S, WD_S, ALUA_S, ALUB_S, INSTR_EN, ALU_OUT_EN, MEM_REG_EN,
           PC_EN, PSR_EN, SE_SIGN, REG_WR, MEM_WE, HALTED
  );
  modport slave (
    output INSTR, PSR_OUT,
    input PC_S, MEM_S, WD_S, ALUA_S, ALUB_S, INSTR_EN, ALU_OUT_EN, MEM_REG_EN,
          PC_EN, PSR_EN, SE_SIGN, REG_WR, MEM_WE, HALTED
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: fetch/decode/execute/memory/writeback sequencer for the 16-bit datapath.
// Optional `CTRL_HALT_EN: illegal encodings park the FSM in HALT until reset.
module multicycle_controller #(
  parameter int WIDTH = 16,
  parameter int PSRL = 5,
  parameter int MEM_LAT = 1
) (
  input logic clk,
  input logic reset,
  multicycle_controller_if.master bus
);
`ifdef CTRL_HALT_EN
  typedef enum logic [3:0] {FETCH, FETCH_LD, DECODE, EXEC_R, EXEC_I, WB, MEM_RD, MEM_WB, MEM_WR,
                            BRANCH, JUMP, HALT} state_t;
  localparam state_t ILLEGAL = HALT;
`else
  typedef enum logic [3:0] {FETCH, FETCH_LD, DECODE, EXEC_R, EXEC_I, WB, MEM_RD, MEM_WB, MEM_WR,
                            BRANCH, JUMP} state_t;
  localparam state_t ILLEGAL = FETCH;
`endif
  localparam logic [2:0] LAT_TC = 3'(MEM_LAT - 1);
  state_t state, state_n;
  logic [2:0] cnt;
  logic [3:0] op, cond, ext, alu_sel;
  logic r_ok, i_ok, is_ld, is_st, is_j, is_b, sets_psr, is_cmp, se, taken;
  logic n, z, f, l, c;
  logic [15:0] conds;
  logic [1:0] wb_sel;
  logic unused_bits;
  function automatic logic alu_code(input logic [3:0] x);
    return x inside {4'b0101, 4'b1001, 4'b1011, 4'b0001, 4'b0010, 4'b0011, 4'b1101};
  endfunction
  assign op = bus.INSTR[WIDTH-1 -: 4];
  assign cond = bus.INSTR[WIDTH-5 -: 4];
  assign ext = bus.INSTR[7:4];
  assign unused_bits = ^bus.INSTR[3:0];
  assign r_ok = op == 4'b0000 && alu_code(ext);
  assign i_ok = op != 4'b0000 && alu_code(op);
  assign is_ld = op == 4'b0100 && ext == 4'b0000;
  assign is_st = op == 4'b0100 && ext == 4'b0100;
  assign is_j = op == 4'b0100 && ext == 4'b1100;
  assign is_b = op == 4'b1100;
  assign alu_sel = op == 4'b0000 ? ext : op;
  assign sets_psr = alu_sel inside {4'b0101, 4'b1001, 4'b1011};
  assign is_cmp = alu_sel == 4'b1011;
  assign se = i_ok && sets_psr;
  assign wb_sel = op == 4'b1101 ? 2'b00 : (op == 4'b0000 && ext == 4'b1101) ? 2'b01 : 2'b11;
  assign {n, z, f, l, c} = {bus.PSR_OUT[PSRL-1], bus.PSR_OUT[3:0]};
  // One bit per condition code, indexed directly by cond (EQ at bit 0, never at bit 15)
  assign conds = {1'b0, 1'b1, n | z, !n & !z, l | z, !l & !z, !f, f, !n, n, !l, l, !c, c, !z, z};
  assign taken = conds[cond];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= (state_n != state || !(state inside {FETCH, MEM_RD})) ? '0 : cnt + 3'd1;
    end
  end
  always_comb begin
    state_n = FETCH;
    case (state)
      FETCH: state_n = cnt == LAT_TC ? FETCH_LD : FETCH;
      FETCH_LD: state_n = DECODE;
      DECODE: state_n = r_ok ? EXEC_R : i_ok ? EXEC_I : is_ld ? MEM_RD : is_st ? MEM_WR :
                        is_j ? JUMP : is_b ? BRANCH : ILLEGAL;
      EXEC_R, EXEC_I: state_n = is_cmp ? FETCH : WB;
      MEM_RD: state_n = cnt == LAT_TC ? MEM_WB : MEM_RD;
`ifdef CTRL_HALT_EN
      HALT: state_n = HALT;
`endif
      default: state_n = FETCH;
    endcase
  end
  always_comb begin
    bus.PC_S = 1'b0;
    bus.MEM_S = 1'b1;
    bus.WD_S = 2'b00;
    bus.ALUA_S = 2'b00;
    bus.ALUB_S = 2'b00;
    bus.INSTR_EN = 1'b0;
    bus.ALU_OUT_EN = 1'b0;
    bus.MEM_REG_EN = 1'b0;
    bus.PC_EN = 1'b0;
    bus.PSR_EN = 1'b0;
    bus.SE_SIGN = 1'b0;
    bus.REG_WR = 1'b0;
    bus.MEM_WE = 1'b0;
    bus.HALTED = 1'b0;
    case (state)
      FETCH_LD: begin
        bus.INSTR_EN = 1'b1;
        bus.PC_EN = 1'b1;
        bus.PC_S = 1'b1;
        bus.ALUA_S = 2'b01;
        bus.ALUB_S = 2'b10;
      end
      DECODE: bus.SE_SIGN = se;
      EXEC_R: begin
        bus.ALU_OUT_EN = 1'b1;
        bus.PSR_EN = sets_psr;
      end
      EXEC_I: begin
        bus.ALUA_S = 2'b10;
        bus.ALUB_S = 2'b01;
        bus.ALU_OUT_EN = 1'b1;
        bus.PSR_EN = sets_psr;
        bus.SE_SIGN = se;
      end
      WB: begin
        bus.REG_WR = 1'b1;
        bus.WD_S = wb_sel;
        bus.SE_SIGN = se;
      end
      MEM_RD: bus.MEM_S = 1'b0;
      MEM_WB: begin
        bus.MEM_S = 1'b0;
        bus.MEM_REG_EN = 1'b1;
        bus.REG_WR = 1'b1;
        bus.WD_S = 2'b10;
      end
      MEM_WR: begin
        bus.MEM_S = 1'b0;
        bus.MEM_WE = 1'b1;
      end
      BRANCH: begin
        bus.ALUA_S = taken ? 2'b01 : 2'b00;
        bus.ALUB_S = taken ? 2'b01 : 2'b00;
        bus.SE_SIGN = taken;
        bus.PC_S = taken;
        bus.PC_EN = taken;
      end
      JUMP: bus.PC_EN = taken;
`ifdef CTRL_HALT_EN
      HALT: bus.HALTED = 1'b1;
`endif
      default: ;
    endcase
  end
endmodule
